// File: rtl/prog_loader.sv
// Byte-serial program loader: parses a framed stream (sync, 16-bit word count,
// big-endian data words, XOR checksum) and writes each assembled word into the
// instruction memory. The CPU is held in reset until a frame loads cleanly.
module prog_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_reload,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [31:0]       o_im_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  // Largest legal word count: one full pass over memory, so no address repeats.
  localparam logic [16:0] MAX_LEN = 17'(64'd1 << ADDR_W);

  logic [2:0]        r_state;
  logic [15:0]       r_count;
  logic [1:0]        r_idx;
  logic [7:0]        r_xor;
  logic [31:0]       r_shift;
  logic              r_im_we;
  logic [ADDR_W-1:0] r_im_addr;
  logic [ADDR_W:0]   r_words;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic [16:0]       w_len_ext;

  // Ready is a pure decode of state so it never depends on byte_valid.
  always_comb begin
    o_byte_ready = 1'b0;
    case (r_state)
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: o_byte_ready = 1'b1;
      default:                                    o_byte_ready = 1'b0;
    endcase
  end

  assign w_accept  = i_byte_valid && o_byte_ready && !i_reload;
  assign w_len_ext = {1'b0, r_count[15:8], i_byte_data};

  // Frame parser, word assembly and memory write sequencing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= 16'd0;
      r_idx      <= 2'd0;
      r_xor      <= 8'd0;
      r_shift    <= 32'd0;
      r_im_we    <= 1'b0;
      r_im_addr  <= '0;
      r_words    <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (i_reload) begin
      // A write already on the bus still lands this edge; it is simply not counted.
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_im_we    <= 1'b0;
      r_im_addr  <= '0;
      r_words    <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_im_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && (i_byte_data == SYNC)) begin
            r_state   <= S_LEN_HI;
            r_xor     <= 8'd0;
            r_idx     <= 2'd0;
            r_words   <= '0;
            r_im_addr <= '0;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_count[15:8] <= i_byte_data;
            r_xor         <= r_xor ^ i_byte_data;
            r_state       <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_count[7:0] <= i_byte_data;
            r_xor        <= r_xor ^ i_byte_data;
            if (w_len_ext > MAX_LEN) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else if (w_len_ext == 17'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_shift <= {r_shift[23:0], i_byte_data};
            r_xor   <= r_xor ^ i_byte_data;
            r_idx   <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_state <= S_WRITE;
              r_im_we <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_im_addr <= r_im_addr + ADDR_W'(1);
          r_words   <= r_words + (ADDR_W+1)'(1);
          r_count   <= r_count - 16'd1;
          r_state   <= (r_count == 16'd1) ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          if (w_accept) begin
            if (i_byte_data == r_xor) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        default: ;  // DONE and ERR are sticky until reload or reset
      endcase
    end
  end

  assign o_im_we        = r_im_we;
  assign o_im_addr      = r_im_addr;
  assign o_im_wdata     = r_shift;
  assign o_cpu_hold     = r_cpu_hold;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_words_loaded = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and random frames compared
// against a frame-level reference model of the loader.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [7:0]  SYNC   = 8'hA5;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_reload = 1'b0;
  logic              i_byte_valid = 1'b0;
  logic [7:0]        i_byte_data = 8'h00;
  logic              o_byte_ready;
  logic              o_im_we;
  logic [ADDR_W-1:0] o_im_addr;
  logic [31:0]       o_im_wdata;
  logic              o_cpu_hold;
  logic              o_done;
  logic              o_err;
  logic [ADDR_W:0]   o_words_loaded;

  prog_loader #(.ADDR_W(ADDR_W), .SYNC(SYNC)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_reload       (i_reload),
    .i_byte_valid   (i_byte_valid),
    .i_byte_data    (i_byte_data),
    .o_byte_ready   (o_byte_ready),
    .o_im_we        (o_im_we),
    .o_im_addr      (o_im_addr),
    .o_im_wdata     (o_im_wdata),
    .o_cpu_hold     (o_cpu_hold),
    .o_done         (o_done),
    .o_err          (o_err),
    .o_words_loaded (o_words_loaded)
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int acc_cnt = 0;

  logic [7:0]  fr_q[$];
  logic [31:0] exp_wr[$];
  logic [31:0] wr_data_q[$];
  int          wr_addr_q[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  // Observe memory writes and accepted bytes mid-cycle, away from the edge.
  always @(negedge i_clk) begin
    if (o_im_we) begin
      wr_addr_q.push_back(int'(o_im_addr));
      wr_data_q.push_back(o_im_wdata);
    end
    if (i_byte_valid && o_byte_ready && !i_reload) acc_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until the loader takes it; returns #1 after that edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, output int t);
    int guard;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge i_clk); #1; end
    i_byte_valid = 1'b1;
    i_byte_data  = b;
    guard = 0;
    forever begin
      @(negedge i_clk);
      if (o_byte_ready) begin
        @(posedge i_clk); #1;
        break;
      end
      guard++;
      if (guard > 200) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    i_byte_valid = 1'b0;
    t = cyc;
  endtask

  task automatic do_reload();
    i_reload = 1'b1;
    @(posedge i_clk); #1;
    i_reload = 1'b0;
    check("reload_done", 64'(o_done), 64'd0);
    check("reload_err", 64'(o_err), 64'd0);
    check("reload_hold", 64'(o_cpu_hold), 64'd1);
    check("reload_words", 64'(o_words_loaded), 64'd0);
    check("reload_addr", 64'(o_im_addr), 64'd0);
    check("reload_ready", 64'(o_byte_ready), 64'd1);
  endtask

  // Build garbage + sync + length + random words + checksum (optionally corrupted).
  task automatic build_frame(input int len, input int garbage, input bit corrupt);
    logic [7:0] x, b;
    fr_q.delete();
    for (int g = 0; g < garbage; g++) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h00;
      fr_q.push_back(b);
    end
    fr_q.push_back(SYNC);
    x = 8'(len >> 8) ^ 8'(len);
    fr_q.push_back(8'(len >> 8));
    fr_q.push_back(8'(len));
    for (int k = 0; k < 4 * len; k++) begin
      b = 8'($urandom);
      x ^= b;
      fr_q.push_back(b);
    end
    fr_q.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  // Reference: interpret the byte list as the frame format describes.
  task automatic model(output int sync_i, output int len, output bit ok, output bit len_err);
    logic [7:0] x;
    int base;
    exp_wr.delete();
    sync_i = 0;
    while (fr_q[sync_i] != SYNC) sync_i++;
    len = int'({fr_q[sync_i+1], fr_q[sync_i+2]});
    x = fr_q[sync_i+1] ^ fr_q[sync_i+2];
    ok = 1'b0;
    len_err = (len > DEPTH);
    if (len_err) return;
    for (int k = 0; k < len; k++) begin
      base = sync_i + 3 + 4 * k;
      exp_wr.push_back({fr_q[base], fr_q[base+1], fr_q[base+2], fr_q[base+3]});
      x ^= fr_q[base] ^ fr_q[base+1] ^ fr_q[base+2] ^ fr_q[base+3];
    end
    ok = (fr_q[sync_i + 3 + 4 * len] == x);
  endtask

  task automatic run_frame(input string tag, input bit gaps);
    int sync_i, len, t_sync, t_last, t, nw;
    bit ok, len_err;
    model(sync_i, len, ok, len_err);
    wr_addr_q.delete();
    wr_data_q.delete();
    acc_cnt = 0;
    t_sync = 0;
    t_last = 0;
    foreach (fr_q[i]) begin
      send_byte(fr_q[i], gaps, t);
      if (i == sync_i) t_sync = t;
      t_last = t;
    end
    // Done must be visible right after the checksum edge.
    if (ok) check({tag, "_done_now"}, 64'(o_done), 64'd1);
    // SYNC..CSUM acceptance edges are 5L+3 apart (5L+4 cycles counting SYNC's).
    if (!gaps && !len_err) check({tag, "_latency"}, 64'(t_last - t_sync), 64'(5 * len + 3));
    repeat (3) @(posedge i_clk);
    #1;
    nw = exp_wr.size();
    check({tag, "_nwrites"}, 64'(wr_data_q.size()), 64'(nw));
    for (int k = 0; k < nw && k < wr_data_q.size(); k++) begin
      check({tag, "_waddr"}, 64'(wr_addr_q[k]), 64'(k % DEPTH));
      check({tag, "_wdata"}, 64'(wr_data_q[k]), 64'(exp_wr[k]));
    end
    check({tag, "_accepted"}, 64'(acc_cnt), 64'(fr_q.size()));
    check({tag, "_done"}, 64'(o_done), 64'(ok));
    check({tag, "_err"}, 64'(o_err), 64'(!ok));
    check({tag, "_hold"}, 64'(o_cpu_hold), 64'(!ok));
    check({tag, "_words"}, 64'(o_words_loaded), 64'(nw));
    check({tag, "_ready"}, 64'(o_byte_ready), 64'd0);
    check({tag, "_we_idle"}, 64'(o_im_we), 64'd0);
  endtask

  initial begin
    int t;
    #12;
    check("rst_ready", 64'(o_byte_ready), 64'd1);
    check("rst_we", 64'(o_im_we), 64'd0);
    check("rst_addr", 64'(o_im_addr), 64'd0);
    check("rst_wdata", 64'(o_im_wdata), 64'd0);
    check("rst_hold", 64'(o_cpu_hold), 64'd1);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("rst_words", 64'(o_words_loaded), 64'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // Known two-word frame with good and with bad checksum.
    fr_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
             8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h02};
    run_frame("fixed_good", 1'b0);
    do_reload();
    fr_q[11] = 8'h03;
    run_frame("fixed_bad", 1'b0);
    do_reload();

    // Garbage ahead of an empty frame.
    fr_q = '{8'h00, 8'hFF, 8'hA4, 8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("garbage", 1'b0);
    do_reload();

    // Length boundaries.
    fr_q = '{8'hA5, 8'h00, 8'h41};
    run_frame("len_over", 1'b0);
    do_reload();
    build_frame(DEPTH, 0, 1'b0);
    run_frame("len_max", 1'b0);
    do_reload();

    // Three words with random valid gaps.
    build_frame(3, 0, 1'b0);
    run_frame("gaps3", 1'b1);
    do_reload();

    // Reload in the middle of word 1, then a fresh one-word frame.
    send_byte(SYNC, 1'b0, t);
    send_byte(8'h00, 1'b0, t);
    send_byte(8'h02, 1'b0, t);
    send_byte(8'h11, 1'b0, t);
    send_byte(8'h22, 1'b0, t);
    do_reload();
    build_frame(1, 0, 1'b0);
    run_frame("after_reload", 1'b0);
    do_reload();

    // Random frames.
    for (int r = 0; r < 6; r++) begin
      build_frame($urandom_range(0, 8), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      run_frame("rand", 1'($urandom_range(0, 1)));
      do_reload();
    end

    // Asynchronous reset while a write is on the bus.
    send_byte(SYNC, 1'b0, t);
    send_byte(8'h00, 1'b0, t);
    send_byte(8'h01, 1'b0, t);
    send_byte(8'hDE, 1'b0, t);
    send_byte(8'hAD, 1'b0, t);
    send_byte(8'hBE, 1'b0, t);
    send_byte(8'hEF, 1'b0, t);
    check("pre_rst_we", 64'(o_im_we), 64'd1);
    check("pre_rst_wdata", 64'(o_im_wdata), 64'hDEADBEEF);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(o_byte_ready), 64'd1);
    check("arst_we", 64'(o_im_we), 64'd0);
    check("arst_addr", 64'(o_im_addr), 64'd0);
    check("arst_wdata", 64'(o_im_wdata), 64'd0);
    check("arst_hold", 64'(o_cpu_hold), 64'd1);
    check("arst_done", 64'(o_done), 64'd0);
    check("arst_err", 64'(o_err), 64'd0);
    check("arst_words", 64'(o_words_loaded), 64'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // Loader must be fully usable after the reset.
    build_frame(2, 1, 1'b0);
    run_frame("post_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-serial program loader that writes the instruction memory of the single-cycle CPU. It receives a framed byte stream (sync, length, big-endian 32-bit words, XOR checksum) over a valid/ready handshake. It assembles each group of four bytes into a word and writes it to consecutive instruction-memory addresses starting at 0. It holds the CPU in reset (`cpu_hold`) until a frame completes with a good checksum.

## Interface
- `ADDR_W`, 6, instruction-memory address width; depth = 2^ADDR_W words
- `SYNC`, 8'hA5, frame start byte
- `clk`  in  1  system clock, all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `reload`  in  1  synchronous restart pulse; abandons any frame and returns to IDLE
- `byte_valid`  in  1  `byte_data` is valid this cycle
- `byte_data`  in  8  incoming stream byte
- `byte_ready`  out  1  loader accepts a byte this cycle
- `im_we`  out  1  instruction-memory write enable, one-cycle pulse per word
- `im_addr`  out  ADDR_W  instruction-memory word address
- `im_wdata`  out  32  assembled instruction word
- `cpu_hold`  out  1  active-high CPU reset/hold request
- `done`  out  1  frame loaded and checksum matched (sticky)
- `err`  out  1  frame rejected (sticky)
- `words_loaded`  out  ADDR_W+1  count of words written in current frame

## Operation
- A byte is accepted on a rising edge when `byte_valid && byte_ready && !reload`.
- `byte_ready` is 1 in IDLE, LEN_HI, LEN_LO, DATA and CSUM. It is 0 in WRITE, DONE and ERR.
- Frame format: `SYNC`, LEN_HI, LEN_LO, then LEN×4 data bytes (MSB first), then CSUM.
- LEN is the number of 32-bit words (16-bit, big-endian).
- Checksum: 8-bit XOR of LEN_HI, LEN_LO and all data bytes. `SYNC` is excluded.
- Internal registers: state, remaining-word count (16b), byte index (2b), running XOR (8b), shift register (32b).
- States and transitions:
  - IDLE: accepted byte == `SYNC` -> LEN_HI; clear XOR, byte index, `words_loaded`, `im_addr`. Any other byte is discarded and the state stays IDLE.
  - LEN_HI: store the byte as count[15:8] -> LEN_LO.
  - LEN_LO: store count[7:0], giving full count L.
    - L > 2^ADDR_W -> ERR.
    - L == 0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: shift the byte into the word register (first byte ends in [31:24]) and increment the byte index. On the 4th byte -> WRITE.
  - WRITE: `im_we`=1 for exactly this cycle with `im_addr`/`im_wdata` stable. On exit, `im_addr`+1 and `words_loaded`+1. Remaining == 1 -> CSUM, else DATA.
  - CSUM: byte == XOR -> DONE, else -> ERR.
  - DONE: `done`=1, `cpu_hold`=0. Stays until `rst` or `reload`.
  - ERR: `err`=1, `cpu_hold`=1. Stays until `rst` or `reload`.
- `reload` in any state forces IDLE, clears `done`, `err`, `words_loaded` and `im_addr`, and sets `cpu_hold`=1. It has priority over byte acceptance.
- `im_addr` wraps modulo 2^ADDR_W. Because L is capped at 2^ADDR_W, no address is ever written twice in one frame.
- Memory contents already written are not rolled back on ERR or `reload`. `cpu_hold` keeps the CPU off them.

## Timing
- Reset values (async assert, `rst`=0):
  - state IDLE, `byte_ready`=1
  - `im_we`=0, `im_addr`=0, `im_wdata`=0
  - `cpu_hold`=1, `done`=0, `err`=0, `words_loaded`=0
  - XOR=0, count=0
- Release of `rst` is assumed synchronized externally. The first byte can be accepted on the first edge after release.
- All outputs are registered except `byte_ready`, which is decoded from state and is combinational-free of `byte_valid`.
- 4th data byte accepted at edge N: WRITE occupies cycle N..N+1, `im_we` is high only in that cycle, and memory captures at edge N+1.
- Sustained throughput: 5 cycles per word (4 byte cycles + 1 write cycle).
- CSUM accepted at edge N: `done`=1 and `cpu_hold`=0 are visible after edge N.
- Frame latency for L words with byte_valid always high: 3 + 5L + 1 cycles from SYNC to DONE.
- `reload` asserted while in WRITE: `im_we` drops after that edge. The write in progress completes, since memory captures on the same edge, and is not counted.
- `byte_valid` gaps are allowed in any accepting state. No timeout.

## Test plan
- Frame A5,00,02,12,34,56,78,9A,BC,DE,F0,CS=0x02 -> writes 0x12345678@0 and 0x9ABCDEF0@1, one `im_we` cycle each; `done`=1, `cpu_hold`=0, `words_loaded`=2.
- Same frame with CS=0x03 -> both words written, then `err`=1, `cpu_hold`=1, `done`=0, `byte_ready`=0.
- Leading garbage 00,FF,A4 before A5,00,00,00 -> garbage discarded, no `im_we`; `done`=1, `words_loaded`=0.
- With ADDR_W=6: LEN=0x0041 -> ERR right after LEN_LO. LEN=0x0040 -> 64 writes, last at `im_addr`=63, `words_loaded`=64, then DONE.
- Random `byte_valid` gaps over a 3-word frame -> identical writes and DONE, and no byte is accepted while `byte_ready`=0 in WRITE.
- `reload` mid-DATA (after 2 bytes of word 1), then a fresh 1-word frame -> new word written at addr 0 with no stale bytes mixed in. Separately, `rst` asserted mid-frame -> all outputs at reset values immediately, without waiting for `clk`.
